jk_ff_checker: RTL and testbench

JK_FF_CHECKER -- requirements
Module: jk_ff_checker

---
 rtl/jk_ff_checker.sv | 139 +++++++++++++
 tb/tb_jk_ff_checker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_ff_checker.sv
// jk_ff_checker: golden JK flip-flop reference that compares three converted
// JK implementations (SR-, D- and T-based) and tracks their mismatches.
// Optional feature macro: JK_CHECKER_TOGGLE_CNT_EN adds the tog_cnt output,
// counting every non-reset edge with j=k=1.
module jk_ff_checker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             j,
    input  logic             k,
    input  logic             q_sr,
    input  logic             q_d,
    input  logic             q_t,
    input  logic             en,
    input  logic             clr,
    output logic             q_ref,
    output logic [2:0]       err_vec,
    output logic [CNT_W-1:0] mm_sr,
    output logic [CNT_W-1:0] mm_d,
    output logic [CNT_W-1:0] mm_t,
    output logic [15:0]      chk_cnt,
    output logic [1:0]       state,
    output logic             fault
`ifdef JK_CHECKER_TOGGLE_CNT_EN
    ,
    output logic [15:0]      tog_cnt
`endif
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] FAULT = 2'b10;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic       primed;
    logic       compare;
    logic [2:0] mismatch;
    logic       any_mismatch;
    logic [1:0] state_next;

    // Saturating increment: a counter that has reached its ceiling stays there.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                  input logic             hit);
        if (hit && (value != CNT_MAX))
            return value + 1'b1;
        return value;
    endfunction

    // Compare each implementation against the reference state from the previous edge.
    always_comb begin
        compare      = primed & en;
        mismatch     = ({q_t, q_d, q_sr} ^ {3{q_ref}}) & {3{compare}};
        any_mismatch = |mismatch;
    end

    // Golden JK update, independent of enable, clear and FSM state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_ref  <= 1'b0;
            primed <= 1'b0;
        end else begin
            primed <= 1'b1;
            case ({j, k})
                2'b01:   q_ref <= 1'b0;
                2'b10:   q_ref <= 1'b1;
                2'b11:   q_ref <= ~q_ref;
                default: q_ref <= q_ref;
            endcase
        end
    end

    // Mismatch pulses and counters; clear reloads them with this edge's result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_vec <= 3'b000;
            mm_sr   <= '0;
            mm_d    <= '0;
            mm_t    <= '0;
            chk_cnt <= 16'd0;
        end else begin
            err_vec <= mismatch;
            if (clr) begin
                mm_sr   <= CNT_W'(mismatch[0]);
                mm_d    <= CNT_W'(mismatch[1]);
                mm_t    <= CNT_W'(mismatch[2]);
                chk_cnt <= 16'(compare);
            end else if (compare) begin
                mm_sr   <= sat_inc(mm_sr, mismatch[0]);
                mm_d    <= sat_inc(mm_d, mismatch[1]);
                mm_t    <= sat_inc(mm_t, mismatch[2]);
                chk_cnt <= chk_cnt + 16'd1;
            end
        end
    end

    // Next-state logic: a mismatch on the IDLE->RUN edge does not cause a fault.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en && primed) state_next = RUN;
            RUN: begin
                if (any_mismatch)
                    state_next = FAULT;
                else if (!en)
                    state_next = IDLE;
            end
            FAULT:   if (clr && !any_mismatch) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Fault flag mirrors the FAULT state.
    always_comb begin
        fault = (state == FAULT);
    end

`ifdef JK_CHECKER_TOGGLE_CNT_EN
    // Count edges that request a toggle; clear takes priority.
    always_ff @(posedge clk) begin
        if (!reset)
            tog_cnt <= 16'd0;
        else if (clr)
            tog_cnt <= 16'd0;
        else if (j && k)
            tog_cnt <= tog_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_jk_ff_checker.sv
// tb_jk_ff_checker: table-driven and randomized bench for jk_ff_checker,
// checked against a behavioural JK reference model kept in the bench.
module tb_jk_ff_checker;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset, j, k, q_sr, q_d, q_t, en, clr;
    logic             q_ref;
    logic [2:0]       err_vec;
    logic [CNT_W-1:0] mm_sr, mm_d, mm_t;
    logic [15:0]      chk_cnt;
    logic [1:0]       state;
    logic             fault;
`ifdef JK_CHECKER_TOGGLE_CNT_EN
    logic [15:0]      tog_cnt;
`endif

    jk_ff_checker #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .j(j), .k(k),
        .q_sr(q_sr), .q_d(q_d), .q_t(q_t), .en(en), .clr(clr),
        .q_ref(q_ref), .err_vec(err_vec),
        .mm_sr(mm_sr), .mm_d(mm_d), .mm_t(mm_t),
        .chk_cnt(chk_cnt), .state(state), .fault(fault)
`ifdef JK_CHECKER_TOGGLE_CNT_EN
        , .tog_cnt(tog_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state (state: 0 idle, 1 run, 2 fault)
    int m_q, m_primed, m_state, m_chk, m_tog;
    int m_mm[3];
    int m_err;

    typedef struct {
        logic       rst, j, k, en, clr;
        logic [2:0] q;
        int         exp_q, exp_err, exp_state, exp_sr, exp_d, exp_t, exp_chk;
    } vec_t;

    vec_t tbl[13];

    task automatic compareField(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic modelReset();
        m_q = 0; m_primed = 0; m_state = 0; m_chk = 0; m_tog = 0; m_err = 0;
        for (int i = 0; i < 3; i++) m_mm[i] = 0;
    endtask

    // One clock edge of the reference JK checker, using the currently driven inputs.
    task automatic modelStep();
        int qin[3];
        int cmp, any;
        qin[0] = q_sr; qin[1] = q_d; qin[2] = q_t;
        if (!reset) begin
            modelReset();
            return;
        end
        cmp = (m_primed == 1 && en) ? 1 : 0;
        m_err = 0;
        for (int i = 0; i < 3; i++)
            if (cmp == 1 && qin[i] != m_q) m_err += (1 << i);
        any = (m_err != 0) ? 1 : 0;
        if (clr) begin
            for (int i = 0; i < 3; i++) m_mm[i] = (m_err >> i) & 1;
            m_chk = cmp;
        end else if (cmp == 1) begin
            m_chk = (m_chk + 1) % 65536;
            for (int i = 0; i < 3; i++)
                if (((m_err >> i) & 1) == 1 && m_mm[i] < CNT_MAX) m_mm[i]++;
        end
        if (m_state == 0) begin
            if (en && m_primed == 1) m_state = 1;
        end else if (m_state == 1) begin
            if (any == 1) m_state = 2;
            else if (!en) m_state = 0;
        end else begin
            if (clr && any == 0) m_state = 0;
        end
        if (clr) m_tog = 0;
        else if (j && k) m_tog = (m_tog + 1) % 65536;
        if (j && k) m_q = 1 - m_q;
        else if (j) m_q = 1;
        else if (k) m_q = 0;
        m_primed = 1;
    endtask

    task automatic applyStimulus(input logic r, input logic jj, input logic kk,
                                 input logic ee, input logic cc, input logic [2:0] qv);
        reset = r; j = jj; k = kk; en = ee; clr = cc;
        q_sr = qv[0]; q_d = qv[1]; q_t = qv[2];
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic checkOutput(input string tag);
        compareField({tag, ".q_ref"},   int'(q_ref),   m_q);
        compareField({tag, ".err_vec"}, int'(err_vec), m_err);
        compareField({tag, ".state"},   int'(state),   m_state);
        compareField({tag, ".fault"},   int'(fault),   (m_state == 2) ? 1 : 0);
        compareField({tag, ".mm_sr"},   int'(mm_sr),   m_mm[0]);
        compareField({tag, ".mm_d"},    int'(mm_d),    m_mm[1]);
        compareField({tag, ".mm_t"},    int'(mm_t),    m_mm[2]);
        compareField({tag, ".chk_cnt"}, int'(chk_cnt), m_chk);
`ifdef JK_CHECKER_TOGGLE_CNT_EN
        compareField({tag, ".tog_cnt"}, int'(tog_cnt), m_tog);
`endif
    endtask

    function automatic logic [2:0] golden();
        return (m_q == 1) ? 3'b111 : 3'b000;
    endfunction

    initial begin
        string tag;
        logic [2:0] qv;
        modelReset();
        reset = 1'b0; j = 0; k = 0; en = 0; clr = 0; q_sr = 0; q_d = 0; q_t = 0;

        // rst, j, k, en, clr, q{t,d,sr} -> q_ref, err_vec, state, mm_sr, mm_d, mm_t, chk_cnt
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b111, 0, 0, 1, 0, 0, 0, 1};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1, 0, 1, 0, 0, 0, 2};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 1, 0, 1, 0, 0, 0, 3};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b101, 0, 2, 2, 0, 1, 0, 4};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 0, 0, 2, 0, 1, 0, 4};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 0, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1, 0, 1, 0, 0, 0, 1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b110, 1, 1, 2, 1, 0, 0, 2};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b110, 1, 1, 2, 1, 0, 0, 1};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 1, 0, 0, 0, 0, 0, 0};

        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].j, tbl[i].k, tbl[i].en, tbl[i].clr, tbl[i].q);
            tag = $sformatf("tbl%0d", i);
            compareField({tag, ".q_ref"},   int'(q_ref),   tbl[i].exp_q);
            compareField({tag, ".err_vec"}, int'(err_vec), tbl[i].exp_err);
            compareField({tag, ".state"},   int'(state),   tbl[i].exp_state);
            compareField({tag, ".fault"},   int'(fault),   (tbl[i].exp_state == 2) ? 1 : 0);
            compareField({tag, ".mm_sr"},   int'(mm_sr),   tbl[i].exp_sr);
            compareField({tag, ".mm_d"},    int'(mm_d),    tbl[i].exp_d);
            compareField({tag, ".mm_t"},    int'(mm_t),    tbl[i].exp_t);
            compareField({tag, ".chk_cnt"}, int'(chk_cnt), tbl[i].exp_chk);
            checkOutput({tag, ".model"});
        end

        // Saturation: q_t wrong on 300 comparing edges
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 300; i++) begin
            qv = golden();
            qv[2] = ~qv[2];
            applyStimulus(1'b1, 1'(i % 2), 1'(i % 3 == 0), 1'b1, 1'b0, qv);
        end
        compareField("sat.mm_t", int'(mm_t), 255);
        checkOutput("sat");
        for (int i = 0; i < 5; i++) begin
            qv = golden();
            qv[2] = ~qv[2];
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, qv);
        end
        compareField("sat_hold.mm_t", int'(mm_t), 255);
        compareField("sat_hold.state", int'(state), 2);

        // Reset while in FAULT with mm_sr=5
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 5; i++) begin
            qv = golden();
            qv[0] = ~qv[0];
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, qv);
        end
        compareField("pre_rst.mm_sr", int'(mm_sr), 5);
        compareField("pre_rst.state", int'(state), 2);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b111);
        compareField("rst.q_ref",   int'(q_ref),   0);
        compareField("rst.state",   int'(state),   0);
        compareField("rst.fault",   int'(fault),   0);
        compareField("rst.mm_sr",   int'(mm_sr),   0);
        compareField("rst.chk_cnt", int'(chk_cnt), 0);
        compareField("rst.err_vec", int'(err_vec), 0);

`ifdef JK_CHECKER_TOGGLE_CNT_EN
        // Toggle counting: ten toggles, then a set
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
            compareField($sformatf("tog%0d.q_ref", i), int'(q_ref), (i % 2 == 0) ? 1 : 0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        compareField("tog.tog_cnt", int'(tog_cnt), 10);
        compareField("tog.q_ref",   int'(q_ref),   1);
`endif

        // Randomized traffic against the reference model
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        for (int i = 0; i < 600; i++) begin
            qv = golden();
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 9) == 0) qv[b] = ~qv[b];
            applyStimulus(1'($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 11) == 0), qv);
            checkOutput($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
